cam_green_stats: RTL and testbench
==================================

# cam_green_stats

Parametrised camera frame-statistics block for the microgreen BNN datapath. It synchronises the asynchronous camera bus (`vsync`/`href`/`pclk`/8-bit data) into the system clock domain and assembles RGB565 pixels from byte pairs. It classifies each pixel as green or not against a runtime threshold and publishes per-frame green, pixel and line counts with a one-cycle valid strobe. The BNN feature stage consumes these counts.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for camera inputs; legal range 2..4.
- `CNT_W`, default 16: width of the pixel and green counters.
- `LINE_W`, default 10: width of the line and column counters.
- `ROI_X0`, `ROI_X1`, `ROI_Y0`, `ROI_Y1`, defaults 0, 1023, 0, 1023: inclusive pixel-column and line window. Used only when `CAM_ROI_EN` is defined.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cam_data` in 8: camera byte bus (async).
- `cam_pclk` in 1: camera pixel clock (async); data is valid at its rising edge.
- `cam_href` in 1: line-valid (async).
- `cam_vsync` in 1: frame sync (async); a rising edge ends the frame.
- `thr_in` in 6: minimum 6-bit green level; sampled at frame start.
- `green_cnt` out CNT_W: green pixels in the last frame.
- `pix_cnt` out CNT_W: pixels counted in the last frame.
- `line_cnt` out LINE_W: lines with at least one byte in the last frame.
- `stat_valid` out 1: one-cycle pulse when the three counts update.
- `frame_busy` out 1: high while in ACTIVE.
- `ovf` out 1: a counter saturated in the last published frame.

## Operation
- Synchronisation:
  - `cam_vsync`, `cam_href` and `cam_pclk` each pass through `SYNC_STAGES` flops.
  - `cam_data` is delayed through the same number of stages so it stays aligned.
  - Edges are detected on the last synchroniser stage versus one extra flop.
- FSM:
  - IDLE → VSYNC on a vsync rise.
  - VSYNC → ACTIVE on a vsync fall. On this transition, clear the working counters and `ovf_work`, and latch `thr_in`.
  - ACTIVE → VSYNC on a vsync rise. On this transition, publish the counts and pulse `stat_valid`.
  - Reset puts the FSM in IDLE. The first frame after reset is never published.
- Byte assembly:
  - Applies only in ACTIVE, with synchronised href high, on each pclk rise.
  - A byte-phase bit alternates between byte0 and byte1.
  - An href rise resets the phase to byte0 and the column counter to 0.
  - An href fall discards an odd trailing byte. If the line received at least one byte, `line_cnt_work` increments.
- Pixel decode:
  - byte0 = RRRRRGGG, byte1 = GGGBBBBB.
  - G6 = {byte0[2:0], byte1[7:5]}, R5 = byte0[7:3], B5 = byte1[4:0].
- Green rule: G6 ≥ latched thr AND G6 > {R5,0} AND G6 > {B5,0}. All compares are unsigned, 6-bit.
- Counting:
  - `pix_cnt_work` increments for every completed pixel.
  - `green_cnt_work` increments for pixels that satisfy the green rule.
  - Both counters saturate at all-ones. Saturation sets `ovf_work`.
  - `line_cnt_work` also saturates at all-ones but does not set `ovf`.
  - The column counter increments per pixel and saturates.
- Boundaries:
  - A vsync rise while href is high closes the line (line counted if it received any byte), discards any partial pixel, then publishes.
  - A pixel completing in the same cycle as the vsync-rise detection is included in the published counts.
  - Bytes outside ACTIVE are ignored.
- Published outputs hold until the next `stat_valid`.

## Timing
- Reset values: `green_cnt`=0, `pix_cnt`=0, `line_cnt`=0, `stat_valid`=0, `frame_busy`=0, `ovf`=0. All internal counters and state are 0/IDLE.
- Camera constraint: `cam_pclk`, `cam_href` and `cam_vsync` high and low phases are each ≥ 2 `clk` periods. `cam_data` is stable ≥ 2 `clk` periods around the pclk rise.
- Edge detect latency: SYNC_STAGES+1 cycles after the pad edge.
- Pixel counter update: 1 cycle after the byte1 edge detect.
- `stat_valid` rises 2 cycles after the vsync-rise detect. Outputs change in that same cycle.
- `frame_busy` follows the FSM state with 1 cycle of latency.

## Configuration
- `CAM_ROI_EN` defined:
  - A pixel is counted in `pix_cnt`/`green_cnt` only if column ∈ [ROI_X0, ROI_X1] and line index ∈ [ROI_Y0, ROI_Y1].
  - The line index is the 0-based `line_cnt_work` value at the time the pixel completes.
  - `line_cnt` still counts all lines.
- `CAM_ROI_EN` undefined: every completed pixel is counted. The ROI parameters are ignored and no ROI logic is synthesised.

## Test plan
- Reset values: reset asserted, then released with inputs idle → all outputs 0 and `stat_valid` never pulses.
- Nominal frame: thr_in=32; vsync pulse, 10 lines of bytes {0x3C,0xA0}, vsync pulse → single `stat_valid`; `green_cnt`=10, `pix_cnt`=10, `line_cnt`=10, `ovf`=0.
- Threshold miss: same frame, thr_in=40 → `green_cnt`=0, `pix_cnt`=10. Also check that a `thr_in` change mid-frame has no effect until the next frame.
- Odd byte count: 10 lines of {0x3C,0xA0,0x3C} → `pix_cnt`=10, `line_cnt`=10. The trailing byte is dropped, and the next line starts at byte0.
- Saturation: CNT_W=4, 20 green pixels → `pix_cnt`=15, `green_cnt`=15, `ovf`=1. The next 2-pixel frame reports `pix_cnt`=2 and `ovf`=0.
- ROI and mid-frame reset:
  - With `CAM_ROI_EN`, ROI_Y0=2, ROI_Y1=5, nominal frame → `pix_cnt`=4, `line_cnt`=10.
  - Reset asserted mid-frame → no `stat_valid` until a full vsync-rise, vsync-fall, vsync-rise sequence completes.

Source files
------------

// File: rtl/cam_green_stats.sv
// Camera frame statistics: synchronises the camera bus, assembles RGB565 pixels and
// publishes per-frame green/pixel/line counts. Define CAM_ROI_EN to restrict pixel counts to a window.
module cam_green_stats #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int LINE_W      = 10,
  parameter int ROI_X0      = 0,
  parameter int ROI_X1      = 1023,
  parameter int ROI_Y0      = 0,
  parameter int ROI_Y1      = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cam_data,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [5:0]        thr_in,
  output logic [CNT_W-1:0]  green_cnt,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic              stat_valid,
  output logic              frame_busy,
  output logic              ovf
);

  // state    | meaning
  // S_IDLE   | after reset, waiting for the first vsync rise
  // S_VSYNC  | inside the vsync pulse, waiting for its fall
  // S_ACTIVE | frame in progress, bytes are assembled and counted
  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_ACTIVE} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || ROI_X0 > ROI_X1 || ROI_Y0 > ROI_Y1) begin : g_bad_param
    $error("cam_green_stats: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] r_vs_sync, r_hr_sync, r_pc_sync;
  logic [7:0]             r_data_sync [SYNC_STAGES];
  logic                   r_vs_d, r_hr_d, r_pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_sync <= '0;
      r_hr_sync <= '0;
      r_pc_sync <= '0;
      r_vs_d    <= 1'b0;
      r_hr_d    <= 1'b0;
      r_pc_d    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
    end else begin
      r_vs_sync <= {r_vs_sync[SYNC_STAGES-2:0], cam_vsync};
      r_hr_sync <= {r_hr_sync[SYNC_STAGES-2:0], cam_href};
      r_pc_sync <= {r_pc_sync[SYNC_STAGES-2:0], cam_pclk};
      r_vs_d    <= r_vs_sync[SYNC_STAGES-1];
      r_hr_d    <= r_hr_sync[SYNC_STAGES-1];
      r_pc_d    <= r_pc_sync[SYNC_STAGES-1];
      r_data_sync[0] <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
    end
  end

  logic       w_vs, w_hr, w_pc;
  logic       w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall, w_pc_rise;
  logic [7:0] w_data;

  assign w_vs      = r_vs_sync[SYNC_STAGES-1];
  assign w_hr      = r_hr_sync[SYNC_STAGES-1];
  assign w_pc      = r_pc_sync[SYNC_STAGES-1];
  assign w_data    = r_data_sync[SYNC_STAGES-1];
  assign w_vs_rise = w_vs & ~r_vs_d;
  assign w_vs_fall = ~w_vs & r_vs_d;
  assign w_hr_rise = w_hr & ~r_hr_d;
  assign w_hr_fall = ~w_hr & r_hr_d;
  assign w_pc_rise = w_pc & ~r_pc_d;

  state_t             r_state;
  logic [5:0]         r_thr;
  logic               r_phase, r_has_byte;
  logic [7:0]         r_byte0;
  logic [CNT_W-1:0]   r_pix_work, r_green_work;
  logic [LINE_W-1:0]  r_line_work;
  logic               r_ovf_work, r_pub_pend;
  logic [CNT_W-1:0]   r_green_cnt, r_pix_cnt;
  logic [LINE_W-1:0]  r_line_cnt;
  logic               r_stat_valid, r_busy, r_ovf;

  logic       w_active, w_phase, w_byte_en, w_pix_done, w_close, w_line_hit;
  logic [5:0] w_g6, w_r5x2, w_b5x2;
  logic       w_green, w_in_roi, w_pix_inc, w_green_inc;

  assign w_active   = (r_state == S_ACTIVE);
  assign w_phase    = w_hr_rise ? 1'b0 : r_phase;
  assign w_byte_en  = w_active & w_hr & w_pc_rise;
  assign w_pix_done = w_byte_en & w_phase;
  // A vsync rise with href still high closes the line just like an href fall.
  assign w_close    = w_active & (w_hr_fall | (w_vs_rise & w_hr));
  assign w_line_hit = w_close & (r_has_byte | w_byte_en);

  assign w_g6    = {r_byte0[2:0], w_data[7:5]};
  assign w_r5x2  = {r_byte0[7:3], 1'b0};
  assign w_b5x2  = {w_data[4:0], 1'b0};
  assign w_green = (w_g6 >= r_thr) && (w_g6 > w_r5x2) && (w_g6 > w_b5x2);

`ifdef CAM_ROI_EN
  logic [LINE_W-1:0] r_col;
  logic [LINE_W-1:0] w_col;

  assign w_col    = w_hr_rise ? '0 : r_col;
  assign w_in_roi = (w_col >= LINE_W'(ROI_X0)) && (w_col <= LINE_W'(ROI_X1)) &&
                    (r_line_work >= LINE_W'(ROI_Y0)) && (r_line_work <= LINE_W'(ROI_Y1));
`else
  assign w_in_roi = 1'b1;
`endif

  assign w_pix_inc   = w_pix_done & w_in_roi;
  assign w_green_inc = w_pix_inc & w_green;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_thr        <= '0;
      r_phase      <= 1'b0;
      r_has_byte   <= 1'b0;
      r_byte0      <= '0;
      r_pix_work   <= '0;
      r_green_work <= '0;
      r_line_work  <= '0;
      r_ovf_work   <= 1'b0;
      r_pub_pend   <= 1'b0;
      r_green_cnt  <= '0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_stat_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_ovf        <= 1'b0;
`ifdef CAM_ROI_EN
      r_col        <= '0;
`endif
    end else begin
      r_stat_valid <= 1'b0;
      r_pub_pend   <= 1'b0;
      r_busy       <= w_active;

      case (r_state)
        S_IDLE: if (w_vs_rise) r_state <= S_VSYNC;
        S_VSYNC: begin
          if (w_vs_fall) begin
            r_state      <= S_ACTIVE;
            r_thr        <= thr_in;
            r_pix_work   <= '0;
            r_green_work <= '0;
            r_line_work  <= '0;
            r_ovf_work   <= 1'b0;
            r_phase      <= 1'b0;
            r_has_byte   <= 1'b0;
`ifdef CAM_ROI_EN
            r_col        <= '0;
`endif
          end
        end
        S_ACTIVE: begin
          if (w_vs_rise) begin
            r_state    <= S_VSYNC;
            r_pub_pend <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_active) begin
        if (w_byte_en) begin
          if (!w_phase) r_byte0 <= w_data;
          r_phase    <= ~w_phase;
          r_has_byte <= 1'b1;
        end else if (w_hr_rise) begin
          r_phase    <= 1'b0;
          r_has_byte <= 1'b0;
        end

`ifdef CAM_ROI_EN
        if (w_pix_done) begin
          if (w_col != '1) r_col <= w_col + 1'b1;
          else             r_col <= w_col;
        end else if (w_hr_rise) begin
          r_col <= '0;
        end
`endif

        if (w_pix_inc) begin
          if (r_pix_work != '1) r_pix_work <= r_pix_work + 1'b1;
          else                  r_ovf_work <= 1'b1;
        end
        if (w_green_inc) begin
          if (r_green_work != '1) r_green_work <= r_green_work + 1'b1;
          else                    r_ovf_work   <= 1'b1;
        end

        // Closing a line drops any odd trailing byte.
        if (w_close) begin
          r_phase    <= 1'b0;
          r_has_byte <= 1'b0;
          if (w_line_hit && r_line_work != '1) r_line_work <= r_line_work + 1'b1;
        end
      end

      // One cycle after the vsync-rise detect so a pixel finishing in that cycle is included.
      if (r_pub_pend) begin
        r_green_cnt  <= r_green_work;
        r_pix_cnt    <= r_pix_work;
        r_line_cnt   <= r_line_work;
        r_ovf        <= r_ovf_work;
        r_stat_valid <= 1'b1;
      end
    end
  end

  assign green_cnt  = r_green_cnt;
  assign pix_cnt    = r_pix_cnt;
  assign line_cnt   = r_line_cnt;
  assign stat_valid = r_stat_valid;
  assign frame_busy = r_busy;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_cam_green_stats.sv
// Bench for cam_green_stats: three instances (default, 4-bit counters, ROI lines 2..5)
// share one camera bus; expected frame statistics are queued per frame and checked on stat_valid.
module tb_cam_green_stats;

`ifdef CAM_ROI_EN
  localparam bit ROI_ON = 1'b1;
`else
  localparam bit ROI_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cam_data = '0;
  logic       cam_pclk = 1'b0, cam_href = 1'b0, cam_vsync = 1'b0;
  logic [5:0] thr_in = '0;

  always #5 clk = ~clk;

  logic [15:0] d_green, d_pix, r_green, r_pix;
  logic [3:0]  s_green, s_pix;
  logic [9:0]  d_line, s_line, r_line;
  logic        d_sv, d_busy, d_ovf, s_sv, s_busy, s_ovf, r_sv, r_busy, r_ovf;

  cam_green_stats u_dut (
    .clk(clk), .rst_n(rst_n), .cam_data(cam_data), .cam_pclk(cam_pclk),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .thr_in(thr_in),
    .green_cnt(d_green), .pix_cnt(d_pix), .line_cnt(d_line),
    .stat_valid(d_sv), .frame_busy(d_busy), .ovf(d_ovf)
  );

  cam_green_stats #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .cam_data(cam_data), .cam_pclk(cam_pclk),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .thr_in(thr_in),
    .green_cnt(s_green), .pix_cnt(s_pix), .line_cnt(s_line),
    .stat_valid(s_sv), .frame_busy(s_busy), .ovf(s_ovf)
  );

  cam_green_stats #(.ROI_Y0(2), .ROI_Y1(5)) u_roi (
    .clk(clk), .rst_n(rst_n), .cam_data(cam_data), .cam_pclk(cam_pclk),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .thr_in(thr_in),
    .green_cnt(r_green), .pix_cnt(r_pix), .line_cnt(r_line),
    .stat_valid(r_sv), .frame_busy(r_busy), .ovf(r_ovf)
  );

  typedef struct packed {
    logic [15:0] g;
    logic [15:0] p;
    logic [9:0]  l;
    logic        o;
  } stat_t;

  typedef struct packed {
    stat_t d;
    stat_t s;
    stat_t r;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Reference frame statistics: every line carries nb bytes alternating b0,b1.
  function automatic stat_t model(input int nl, input int nb, input logic [7:0] b0,
                                  input logic [7:0] b1, input logic [5:0] thr, input int cw,
                                  input int y0, input int y1, input bit roi);
    stat_t      m;
    int         maxv = (1 << cw) - 1;
    int         p = 0, g = 0;
    bit         o = 1'b0;
    logic [5:0] g6, r2, bl2;
    bit         isg;
    g6  = {b0[2:0], b1[7:5]};
    r2  = {b0[7:3], 1'b0};
    bl2 = {b1[4:0], 1'b0};
    isg = (g6 >= thr) && (g6 > r2) && (g6 > bl2);
    for (int l = 0; l < nl; l++) begin
      if (roi && (l < y0 || l > y1)) continue;
      for (int k = 0; k < nb / 2; k++) begin
        if (p == maxv) o = 1'b1; else p++;
        if (isg) begin
          if (g == maxv) o = 1'b1; else g++;
        end
      end
    end
    m.g = 16'(g);
    m.p = 16'(p);
    m.l = (nb > 0) ? 10'(nl) : 10'd0;
    m.o = o;
    return m;
  endfunction

  task automatic push_frame(input int nl, input int nb, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [5:0] thr);
    exp_t e;
    e.d = model(nl, nb, b0, b1, thr, 16, 0, 1023, 1'b0);
    e.s = model(nl, nb, b0, b1, thr, 4, 0, 1023, 1'b0);
    e.r = model(nl, nb, b0, b1, thr, 16, 2, 5, ROI_ON);
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (d_sv) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_stat_valid", 32'(d_sv), 0);
      end else begin
        e = sb_q.pop_front();
        chk_eq("dut_green", 32'(d_green), 32'(e.d.g));
        chk_eq("dut_pix",   32'(d_pix),   32'(e.d.p));
        chk_eq("dut_line",  32'(d_line),  32'(e.d.l));
        chk_eq("dut_ovf",   32'(d_ovf),   32'(e.d.o));
        chk_eq("sat_sv",    32'(s_sv),    1);
        chk_eq("sat_green", 32'(s_green), 32'(e.s.g));
        chk_eq("sat_pix",   32'(s_pix),   32'(e.s.p));
        chk_eq("sat_ovf",   32'(s_ovf),   32'(e.s.o));
        chk_eq("roi_sv",    32'(r_sv),    1);
        chk_eq("roi_pix",   32'(r_pix),   32'(e.r.p));
        chk_eq("roi_green", 32'(r_green), 32'(e.r.g));
        chk_eq("roi_line",  32'(r_line),  32'(e.r.l));
      end
    end else if (s_sv || r_sv) begin
      chk_eq("stray_stat_valid", {30'd0, s_sv, r_sv}, 0);
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    clk_wait(3);
    cam_pclk = 1'b1;
    clk_wait(3);
    cam_pclk = 1'b0;
  endtask

  task automatic send_lines(input int nl, input int nb, input logic [7:0] b0, input logic [7:0] b1);
    for (int l = 0; l < nl; l++) begin
      cam_href = 1'b1;
      clk_wait(3);
      for (int i = 0; i < nb; i++) send_byte((i % 2) ? b1 : b0);
      clk_wait(3);
      cam_href = 1'b0;
      clk_wait(4);
    end
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    clk_wait(8);
    cam_vsync = 1'b0;
    clk_wait(8);
  endtask

  task automatic chk_idle_outputs(input string tag);
    @(negedge clk);
    chk_eq({tag, "_green"}, 32'(d_green), 0);
    chk_eq({tag, "_pix"},   32'(d_pix),   0);
    chk_eq({tag, "_line"},  32'(d_line),  0);
    chk_eq({tag, "_sv"},    32'(d_sv),    0);
    chk_eq({tag, "_busy"},  32'(d_busy),  0);
    chk_eq({tag, "_ovf"},   32'(d_ovf),   0);
  endtask

  initial begin
    clk_wait(5);
    rst_n = 1'b1;
    clk_wait(40);
    chk_idle_outputs("reset");

    thr_in = 6'd32;
    vsync_pulse();

    // nominal frame
    send_lines(10, 2, 8'h3C, 8'hA0);
    @(negedge clk);
    chk_eq("busy_active", 32'(d_busy), 1);
    push_frame(10, 2, 8'h3C, 8'hA0, 6'd32);
    thr_in = 6'd40;
    vsync_pulse();

    // threshold miss
    send_lines(10, 2, 8'h3C, 8'hA0);
    push_frame(10, 2, 8'h3C, 8'hA0, 6'd40);
    thr_in = 6'd32;
    vsync_pulse();

    // threshold raised mid-frame has no effect on this frame
    send_lines(5, 2, 8'h3C, 8'hA0);
    thr_in = 6'd40;
    send_lines(5, 2, 8'h3C, 8'hA0);
    push_frame(10, 2, 8'h3C, 8'hA0, 6'd32);
    thr_in = 6'd32;
    vsync_pulse();

    // odd byte count per line
    send_lines(10, 3, 8'h3C, 8'hA0);
    push_frame(10, 3, 8'h3C, 8'hA0, 6'd32);
    vsync_pulse();

    // 20 green pixels saturate the 4-bit instance
    send_lines(20, 2, 8'h3C, 8'hA0);
    push_frame(20, 2, 8'h3C, 8'hA0, 6'd32);
    vsync_pulse();

    // 2-pixel frame clears ovf
    send_lines(1, 4, 8'h3C, 8'hA0);
    push_frame(1, 4, 8'h3C, 8'hA0, 6'd32);
    vsync_pulse();

    // non-green colour: strong red
    send_lines(3, 2, 8'hFC, 8'hA0);
    push_frame(3, 2, 8'hFC, 8'hA0, 6'd32);
    vsync_pulse();

    // reset in the middle of a frame
    send_lines(3, 2, 8'h3C, 8'hA0);
    rst_n = 1'b0;
    clk_wait(4);
    rst_n = 1'b1;
    chk_idle_outputs("midrst");
    send_lines(3, 2, 8'h3C, 8'hA0);
    vsync_pulse();
    send_lines(10, 2, 8'h3C, 8'hA0);
    push_frame(10, 2, 8'h3C, 8'hA0, 6'd32);
    vsync_pulse();

    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    chk_eq("sb_drain", 32'(sb_q.size()), 0);
    clk_wait(20);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
